// File: rtl/mem_arbiter.sv
// Shares one registered memory bus port between instruction fetch and MEM-stage data access.
// Optional access timeout with err_o pulse is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_inst_o,
  output logic        if_ready_o,
  input  logic        dm_ce_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

  state_t      state_q, state_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        bus_ce_q, bus_ce_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        err_q, err_d;

  logic pend_if, pend_dm;
  logic timeout, acc_done;
  logic load_if, load_dm, go_idle;

  logic unused_stall;
  assign unused_stall = ^{stall_i[5:4], stall_i[2:1]};

  assign pend_if  = if_ce_i & ~if_done_q;
  assign pend_dm  = dm_ce_i & ~dm_done_q;
  assign acc_done = (state_q != IDLE) & (bus_ack_i | timeout);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(WAIT_MAX + 1) > 5) ? $clog2(WAIT_MAX + 1) : 5;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  assign timeout = (state_q != IDLE) & ~bus_ack_i & (wait_cnt_q == CW'(WAIT_MAX - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (load_if | load_dm) begin
      wait_cnt_d = '0;
    end else if ((state_q != IDLE) & ~bus_ack_i) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_wait_max;
  assign unused_wait_max = ^WAIT_MAX;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    if_done_d   = if_done_q & stall_i[0];
    dm_done_d   = dm_done_q & stall_i[3];
    if_inst_d   = if_inst_q;
    dm_rdata_d  = dm_rdata_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    err_d       = timeout;
    load_if     = 1'b0;
    load_dm     = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_dm) begin
          load_dm = 1'b1;
        end else if (pend_if) begin
          load_if = 1'b1;
        end
      end
      IF_ACC: begin
        if (acc_done) begin
          if_done_d = 1'b1;
          if_inst_d = timeout ? 32'h0 : bus_rdata_i;
          if (pend_dm) begin
            load_dm = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      DM_ACC: begin
        if (acc_done) begin
          dm_done_d  = 1'b1;
          dm_rdata_d = (bus_we_q | timeout) ? 32'h0 : bus_rdata_i;
          if (pend_if) begin
            load_if = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    // A grant or switch captures the requester's inputs; later changes are ignored.
    if (load_dm) begin
      state_d     = DM_ACC;
      bus_ce_d    = 1'b1;
      bus_we_d    = dm_we_i;
      bus_sel_d   = dm_sel_i;
      bus_addr_d  = dm_addr_i;
      bus_wdata_d = dm_wdata_i;
    end else if (load_if) begin
      state_d     = IF_ACC;
      bus_ce_d    = 1'b1;
      bus_we_d    = 1'b0;
      bus_sel_d   = 4'b1111;
      bus_addr_d  = if_addr_i;
      bus_wdata_d = 32'h0;
    end else if (go_idle) begin
      state_d  = IDLE;
      bus_ce_d = 1'b0;
      bus_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_inst_q   <= 32'h0;
      dm_rdata_q  <= 32'h0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_inst_q   <= if_inst_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_inst_o   = if_inst_q;
  assign if_ready_o  = if_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ready_o  = dm_done_q;
  assign bus_ce_o    = bus_ce_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign stallreq_o  = pend_if | pend_dm;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level pipeline/memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        if_ready_o;
  logic        dm_ce_i, dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        dm_ready_o;
  logic        bus_ce_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          w;
  } acc_t;

  acc_t        log_q[$];
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  bit          auto_resp = 1'b0;
  bit          resp_new = 1'b1;
  int          resp_wait = 0;
  int          resp_w0 = 0;

  mem_arbiter #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o), .if_ready_o(if_ready_o),
    .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory slave: random 0..2 wait states per access, records every completed access.
  task automatic respond();
    acc_t e;
    int   idx;
    if (!bus_ce_o) begin
      bus_ack_i = 1'b0;
      resp_new  = 1'b1;
    end else begin
      if (resp_new) begin
        resp_wait = $urandom_range(0, 2);
        resp_w0   = resp_wait;
        resp_new  = 1'b0;
      end
      if (resp_wait == 0) begin
        idx         = int'(bus_addr_o[5:2]);
        bus_ack_i   = 1'b1;
        bus_rdata_i = mem[idx];
        if (bus_we_o) mem[idx] = merge(mem[idx], bus_wdata_o, bus_sel_o);
        e.we = bus_we_o; e.addr = bus_addr_o; e.sel = bus_sel_o;
        e.wdata = bus_wdata_o; e.w = resp_w0;
        log_q.push_back(e);
        resp_new = 1'b1;
      end else begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        resp_wait--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (auto_resp) respond();
  endtask

  initial begin
    bit          err_seen;
    int          n, exp_n, exp_cnt;
    logic [31:0] exp_if, exp_dm;
    int          ii, di;
    acc_t        e;

    rst = 1'b1; stall_i = 6'h3f; if_ce_i = 1'b1; if_addr_i = 32'h0;
    dm_ce_i = 1'b0; dm_we_i = 1'b0; dm_sel_i = 4'hf; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    bus_rdata_i = 32'h0; bus_ack_i = 1'b0;

    // Reset, then first fetch with zero-wait ack
    step(); step();
    check("rst_bus_ce", {31'b0, bus_ce_o}, 32'h0);
    check("rst_if_ready", {31'b0, if_ready_o}, 32'h0);
    check("rst_dm_ready", {31'b0, dm_ready_o}, 32'h0);
    check("rst_if_inst", if_inst_o, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_stallreq", {31'b0, stallreq_o}, 32'h1);
    rst = 1'b0;
    step();
    check("f1_bus_ce", {31'b0, bus_ce_o}, 32'h1);
    check("f1_bus_addr", bus_addr_o, 32'h0);
    check("f1_bus_we", {31'b0, bus_we_o}, 32'h0);
    check("f1_bus_sel", {28'b0, bus_sel_o}, 32'hf);
    check("f1_ready_early", {31'b0, if_ready_o}, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3C010101;
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    check("f1_inst", if_inst_o, 32'h3C010101);
    check("f1_ready", {31'b0, if_ready_o}, 32'h1);
    check("f1_stallreq", {31'b0, stallreq_o}, 32'h0);
    check("f1_bus_idle", {31'b0, bus_ce_o}, 32'h0);

    // Held pipeline: no re-fetch, instruction stable
    step(); step(); step();
    check("hold_inst", if_inst_o, 32'h3C010101);
    check("hold_no_refetch", {31'b0, bus_ce_o}, 32'h0);
    check("hold_ready", {31'b0, if_ready_o}, 32'h1);
    if_addr_i = 32'h4; stall_i = 6'h0;
    step();
    check("adv_ready_clr", {31'b0, if_ready_o}, 32'h0);
    check("adv_stallreq", {31'b0, stallreq_o}, 32'h1);
    stall_i = 6'h3f;
    step();
    check("f2_bus_addr", bus_addr_o, 32'h4);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h11111111;
    step();
    bus_ack_i = 1'b0;
    check("f2_inst", if_inst_o, 32'h11111111);

    // Simultaneous fetch and data read: data first, no idle gap
    if_addr_i = 32'h10; dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h80; stall_i = 6'h0;
    step();
    stall_i = 6'h3f;
    check("both_dm_first", bus_addr_o, 32'h80);
    check("both_dm_we", {31'b0, bus_we_o}, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA5555;
    step();
    check("both_dm_rdata", dm_rdata_o, 32'hAAAA5555);
    check("both_dm_ready", {31'b0, dm_ready_o}, 32'h1);
    check("both_switch_ce", {31'b0, bus_ce_o}, 32'h1);
    check("both_switch_addr", bus_addr_o, 32'h10);
    check("both_stall_mid", {31'b0, stallreq_o}, 32'h1);
    bus_rdata_i = 32'h12345678;
    step();
    bus_ack_i = 1'b0;
    check("both_if_inst", if_inst_o, 32'h12345678);
    check("both_if_ready", {31'b0, if_ready_o}, 32'h1);
    check("both_stall_end", {31'b0, stallreq_o}, 32'h0);
    check("both_dm_hold", dm_rdata_o, 32'hAAAA5555);

    // Data write
    stall_i = 6'h0;
    step();
    if_ce_i = 1'b0; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_sel_i = 4'b0011;
    dm_wdata_i = 32'hDEADBEEF; stall_i = 6'h3f;
    step();
    check("wr_bus_we", {31'b0, bus_we_o}, 32'h1);
    check("wr_bus_sel", {28'b0, bus_sel_o}, 32'h3);
    check("wr_bus_wdata", bus_wdata_o, 32'hDEADBEEF);
    check("wr_bus_addr", bus_addr_o, 32'h100);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    step();
    bus_ack_i = 1'b0;
    check("wr_dm_ready", {31'b0, dm_ready_o}, 32'h1);
    check("wr_dm_rdata", dm_rdata_o, 32'h0);

    // Reset in the middle of a data access, late ack ignored
    stall_i = 6'h0;
    step();
    dm_we_i = 1'b0; dm_addr_i = 32'h40; dm_sel_i = 4'hf; stall_i = 6'h3f;
    step();
    check("rstmid_grant", {31'b0, bus_ce_o}, 32'h1);
    rst = 1'b1;
    step();
    check("rstmid_bus_ce", {31'b0, bus_ce_o}, 32'h0);
    check("rstmid_bus_addr", bus_addr_o, 32'h0);
    check("rstmid_if_inst", if_inst_o, 32'h0);
    check("rstmid_dm_ready", {31'b0, dm_ready_o}, 32'h0);
    rst = 1'b0; dm_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
    step();
    bus_ack_i = 1'b0;
    check("late_ack_dm_ready", {31'b0, dm_ready_o}, 32'h0);
    check("late_ack_rdata", dm_rdata_o, 32'h0);
    check("late_ack_bus_ce", {31'b0, bus_ce_o}, 32'h0);
    check("late_ack_err", {31'b0, err_o}, 32'h0);

`ifdef ARB_TIMEOUT_EN
    // Data access never acked times out after 15 ACC cycles; pending fetch follows
    if_ce_i = 1'b1; if_addr_i = 32'h20; dm_ce_i = 1'b1; dm_addr_i = 32'h44; stall_i = 6'h3f;
    step();
    err_seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      err_seen |= err_o;
    end
    check("to_no_early_err", {31'b0, err_seen}, 32'h0);
    check("to_not_ready", {31'b0, dm_ready_o}, 32'h0);
    check("to_bus_addr_wait", bus_addr_o, 32'h44);
    step();
    check("to_err", {31'b0, err_o}, 32'h1);
    check("to_dm_ready", {31'b0, dm_ready_o}, 32'h1);
    check("to_dm_rdata", dm_rdata_o, 32'h0);
    check("to_if_granted", bus_addr_o, 32'h20);
    check("to_if_ce", {31'b0, bus_ce_o}, 32'h1);
    step();
    check("to_err_pulse", {31'b0, err_o}, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
    step();
    bus_ack_i = 1'b0;
    check("to_if_inst", if_inst_o, 32'hCAFEF00D);
`endif

    // Randomized pipeline traffic against the transaction-level model
    if_ce_i = 1'b0; dm_ce_i = 1'b0; stall_i = 6'h0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    log_q.delete();
    auto_resp = 1'b1;
    for (int t = 0; t < 40; t++) begin
      ii = $urandom_range(0, 15);
      di = $urandom_range(0, 15);
      if_ce_i = 1'b1; if_addr_i = 32'(ii * 4);
      dm_ce_i = 1'($urandom_range(0, 1)); dm_we_i = 1'($urandom_range(0, 1));
      dm_sel_i = 4'($urandom_range(1, 15)); dm_addr_i = 32'(di * 4); dm_wdata_i = $urandom;
      stall_i = 6'h3f;
      // Model: data access completes before the fetch of the same pipeline cycle
      exp_dm = 32'h0;
      if (dm_ce_i) begin
        if (dm_we_i) ref_mem[di] = merge(ref_mem[di], dm_wdata_i, dm_sel_i);
        else exp_dm = ref_mem[di];
      end
      exp_if  = ref_mem[ii];
      exp_cnt = dm_ce_i ? 2 : 1;
      n = 0;
      do begin
        step();
        n++;
      end while (stallreq_o && n < 60);
      check($sformatf("r%0d_if_inst", t), if_inst_o, exp_if);
      check($sformatf("r%0d_if_ready", t), {31'b0, if_ready_o}, 32'h1);
      if (dm_ce_i) begin
        check($sformatf("r%0d_dm_rdata", t), dm_rdata_o, exp_dm);
        check($sformatf("r%0d_dm_ready", t), {31'b0, dm_ready_o}, 32'h1);
      end
      check($sformatf("r%0d_nacc", t), 32'(log_q.size()), 32'(exp_cnt));
      exp_n = 1;
      if (log_q.size() == exp_cnt) begin
        if (dm_ce_i) begin
          e = log_q.pop_front();
          exp_n += e.w + 1;
          check($sformatf("r%0d_dm_acc", t), {e.addr[27:0], e.sel},
                {dm_addr_i[27:0], dm_sel_i});
          check($sformatf("r%0d_dm_we", t), {31'b0, e.we}, {31'b0, dm_we_i});
          if (dm_we_i) check($sformatf("r%0d_dm_wdata", t), e.wdata, dm_wdata_i);
        end
        e = log_q.pop_front();
        exp_n += e.w + 1;
        check($sformatf("r%0d_if_acc", t), {e.addr[27:0], e.sel}, {if_addr_i[27:0], 4'hf});
        check($sformatf("r%0d_if_we", t), {31'b0, e.we}, 32'h0);
      end
      log_q.delete();
      check($sformatf("r%0d_edges", t), 32'(n), 32'(exp_n));
      stall_i = 6'h0;
      step();
    end
    auto_resp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one external memory bus port between instruction fetch (IF) and MEM-stage data access.
- Sits between `pc_reg`/`if_id`, `mem` and the memory bus; raises a stall request to `ctrl` until every pending access of the current pipeline cycle is served.
- Data access has priority. Completed results are held stable until the pipeline advances.

## Interface
- `WAIT_MAX`, default 15: bus cycles to wait for `bus_ack_i` before an access is aborted. Used only with `ARB_TIMEOUT_EN`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `stall_i` in 6: stall vector from `ctrl`.
  - Bit 0 = PC hold.
  - Bit 3 = EX/MEM register hold.
- `if_ce_i` in 1: fetch request (`rom_ce_o` of `pc_reg`).
- `if_addr_i` in 32: fetch address (pc).
- `if_inst_o` out 32: fetched instruction (`rom_data_i` of core).
- `if_ready_o` out 1: fetch result valid (level).
- `dm_ce_i` in 1: data request.
- `dm_we_i` in 1: 1 = write.
- `dm_sel_i` in 4: byte enables.
- `dm_addr_i` in 32: data address.
- `dm_wdata_i` in 32: write data.
- `dm_rdata_o` out 32: read data.
- `dm_ready_o` out 1: data result valid (level).
- `bus_ce_o` out 1: bus access strobe, registered.
- `bus_we_o` out 1: bus write, registered.
- `bus_sel_o` out 4: bus byte enables, registered.
- `bus_addr_o` out 32: bus address, registered.
- `bus_wdata_o` out 32: bus write data, registered.
- `bus_rdata_i` in 32: bus read data.
- `bus_ack_i` in 1: access complete; sampled only while `bus_ce_o`=1.
- `stallreq_o` out 1: stall request to `ctrl`.
- `err_o` out 1: one-cycle pulse on access timeout.

## Operation
- States: `IDLE`, `IF_ACC`, `DM_ACC`.
- Done flags `if_done` and `dm_done`:
  - `if_ready_o`=`if_done`.
  - `dm_ready_o`=`dm_done`.
  - `if_inst_o` and `dm_rdata_o` come from holding registers.
- `stallreq_o` = (`if_ce_i` & ~`if_done`) | (`dm_ce_i` & ~`dm_done`). Combinational from inputs and registered flags only; it does not depend on `stall_i`, so there is no loop.
- `IDLE`:
  - If `dm_ce_i` & ~`dm_done`, go to `DM_ACC`.
  - Otherwise, if `if_ce_i` & ~`if_done`, go to `IF_ACC`.
  - Otherwise stay in `IDLE`.
  - On entry to an ACC state, the bus registers load the granted requester's address, sel, we and wdata, and `bus_ce_o` goes to 1.
- Fetch accesses: `bus_we_o`=0, `bus_sel_o`=4'b1111.
- Requester inputs that change during an access are ignored; the captured access completes.
- On `bus_ack_i` in an ACC state:
  - Set the owner's done flag.
  - Reads: latch `bus_rdata_i` into the owner's holding register.
  - Writes: load 0 into `dm_rdata_o`.
  - If the other requester is pending and not done, go directly to its ACC state with the bus registers reloaded and `bus_ce_o` kept at 1.
  - Otherwise go to `IDLE` with `bus_ce_o`=0.
- Done-flag clearing:
  - `if_done` clears on an edge with `stall_i[0]`=0 (pc advances, new fetch).
  - `dm_done` clears on an edge with `stall_i[3]`=0 (new MEM instruction).
  - Set and clear on the same edge: clear wins only if no ack occurs that edge. An ack sets the flag.
- A requester with ce=0 is never granted. Its done flag still clears per the rules above.
- Reset:
  - State `IDLE`; all done flags 0.
  - `bus_ce_o`/`bus_we_o` = 0; `bus_sel_o`/`bus_addr_o`/`bus_wdata_o` = 0.
  - `if_inst_o`/`dm_rdata_o` = 0; `err_o` = 0; wait counter 0.
  - Reset mid-access abandons the access immediately. A late `bus_ack_i` arriving in `IDLE` is ignored.

## Timing
- Minimum access: grant edge, then ack in the first ACC cycle, so the result is registered 2 edges after the request is seen in `IDLE`.
- Back-to-back data then fetch, each with a zero-wait ack: both done after 3 edges. `stallreq_o` falls the cycle after the second ack.
- Bus outputs are registered and change only on grant, switch or return to `IDLE`.
- `if_inst_o`/`dm_rdata_o` are stable from the done-set edge until the next access of the same requester completes.
- `err_o` is high for exactly one cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A 5+ bit wait counter resets on each grant and increments every ACC cycle without ack.
  - When the count reaches `WAIT_MAX` with no ack: end the access as completed, load 0 into the owner's holding register, pulse `err_o`, and proceed as on ack.
- Not defined:
  - No counter; accesses wait indefinitely for `bus_ack_i`.
  - `err_o` tied 0; `WAIT_MAX` unused.

## Test plan
- Reset with `if_ce_i`=1 and `if_addr_i`=0x0, ack in the first ACC cycle returning 0x3C010101 -> `bus_addr_o`=0x0 and `bus_we_o`=0. `if_inst_o`=0x3C010101 and `if_ready_o`=1 two edges after request; `stallreq_o` 1 then 0.
- Simultaneous fetch 0x10 and data read 0x80, zero-wait acks -> data granted first (`bus_addr_o`=0x80), then 0x10 with no `IDLE` gap. `stallreq_o` low on the cycle after the second ack.
- Data write: addr 0x100, sel 4'b0011, wdata 0xDEADBEEF -> `bus_we_o`=1, `bus_sel_o`=4'b0011, `bus_wdata_o`=0xDEADBEEF. `dm_rdata_o`=0 after ack.
- Hold `stall_i[0]`=1 after fetch done -> `if_inst_o` held and no re-fetch. Drop to 0 -> `if_done` cleared and new pc fetched.
- `rst` asserted during `DM_ACC` with ack 1 cycle later -> all outputs reset the next edge. The late ack is ignored; `dm_ready_o` stays 0.
- With `ARB_TIMEOUT_EN`, `WAIT_MAX`=15, ack never asserted -> after 15 ACC cycles: `err_o` pulses once, `dm_rdata_o`=0, `dm_ready_o`=1, and the pending fetch is granted next.
